// File: rtl/sigdel_dac_mc.sv
// Multi-channel sigma-delta DAC: frames are buffered over valid/ready, held for OSR clocks
// and fed to per-channel 1st-order (carry) or 2nd-order (saturating CIFB) modulators.
module sigdel_dac_mc #(
   parameter int BITLEN   = 16,
   parameter int CHANNELS = 2,
   parameter int OSR      = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         order_sel,
   input  logic [CHANNELS*BITLEN-1:0]   in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [CHANNELS-1:0]          out,
   output logic                         sample_tick,
   output logic                         underrun,
   output logic [15:0]                  underrun_cnt,
   output logic                         order_active
);

   localparam int CW = (OSR > 2) ? $clog2(OSR) : 1;
   localparam int SW = BITLEN + 5;
   localparam logic signed [SW-1:0] HALF   = SW'(2 ** (BITLEN - 1));
   localparam logic signed [SW-1:0] I1_MAX = SW'(2 ** (BITLEN + 1) - 1);
   localparam logic signed [SW-1:0] I1_MIN = SW'(-(2 ** (BITLEN + 1)));
   localparam logic signed [SW-1:0] I2_MAX = SW'(2 ** (BITLEN + 3) - 1);
   localparam logic signed [SW-1:0] I2_MIN = SW'(-(2 ** (BITLEN + 3)));

   logic [CW-1:0]                count_reg;
   logic [CHANNELS*BITLEN-1:0]   pend_reg;
   logic                         pend_full_reg;
   logic [CHANNELS*BITLEN-1:0]   held_reg;
   logic                         sample_tick_reg;
   logic                         underrun_reg;
   logic [15:0]                  underrun_cnt_reg;
   logic                         order_active_reg;
   logic                         tick;
   logic                         accept;
   logic                         mode_clear;

   assign tick       = en && (count_reg == CW'(OSR - 1));
   assign accept     = in_valid && !pend_full_reg;
   assign mode_clear = tick && (order_sel != order_active_reg);

   assign in_ready     = !pend_full_reg;
   assign sample_tick  = sample_tick_reg;
   assign underrun     = underrun_reg;
   assign underrun_cnt = underrun_cnt_reg;
   assign order_active = order_active_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg        <= '0;
         pend_reg         <= '0;
         pend_full_reg    <= 1'b0;
         held_reg         <= '0;
         sample_tick_reg  <= 1'b0;
         underrun_reg     <= 1'b0;
         underrun_cnt_reg <= '0;
         order_active_reg <= 1'b0;
      end else begin
         if (!en || tick)
            count_reg <= '0;
         else
            count_reg <= count_reg + CW'(1);
         sample_tick_reg <= tick;
         underrun_reg    <= tick && !pend_full_reg;
         if (tick && !pend_full_reg && underrun_cnt_reg != 16'hFFFF)
            underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
         if (tick)
            order_active_reg <= order_sel;
         if (tick && pend_full_reg)
            held_reg <= pend_reg;
         // A frame accepted on the tick lands in pend; in_ready is low whenever pend is full,
         // so an accept and a pend->held transfer never coincide.
         if (accept) begin
            pend_reg      <= in_data;
            pend_full_reg <= 1'b1;
         end else if (tick) begin
            pend_full_reg <= 1'b0;
         end
      end
   end

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [BITLEN-1:0]         x;
      logic [BITLEN:0]           acc_reg;
      logic [BITLEN:0]           acc_next;
      logic signed [BITLEN+1:0]  i1_reg;
      logic signed [BITLEN+1:0]  i1_next;
      logic signed [BITLEN+3:0]  i2_reg;
      logic signed [BITLEN+3:0]  i2_next;
      logic                      out_reg;
      logic signed [SW-1:0]      xs;
      logic signed [SW-1:0]      fb;
      logic signed [SW-1:0]      s1;
      logic signed [SW-1:0]      s2;

      assign x = held_reg[gi*BITLEN +: BITLEN];

      // Sums are formed wide enough that they cannot overflow, then clamped to the integrator range.
      always_comb begin
         acc_next = {1'b0, acc_reg[BITLEN-1:0]} + {1'b0, x};
         xs       = $signed(SW'({1'b0, x})) - HALF;
         fb       = out_reg ? HALF : -HALF;
         s1       = SW'(i1_reg) + xs - fb;
         s2       = SW'(i2_reg) + SW'(i1_reg) - fb;
         if (s1 > I1_MAX)
            i1_next = (BITLEN+2)'(I1_MAX);
         else if (s1 < I1_MIN)
            i1_next = (BITLEN+2)'(I1_MIN);
         else
            i1_next = (BITLEN+2)'(s1);
         if (s2 > I2_MAX)
            i2_next = (BITLEN+4)'(I2_MAX);
         else if (s2 < I2_MIN)
            i2_next = (BITLEN+4)'(I2_MIN);
         else
            i2_next = (BITLEN+4)'(s2);
      end

      always_ff @(posedge clk) begin
         if (rst || !en) begin
            acc_reg <= '0;
            i1_reg  <= '0;
            i2_reg  <= '0;
            out_reg <= 1'b0;
         end else begin
            out_reg <= order_active_reg ? !i2_reg[BITLEN+3] : acc_reg[BITLEN];
            if (mode_clear) begin
               acc_reg <= '0;
               i1_reg  <= '0;
               i2_reg  <= '0;
            end else if (order_active_reg) begin
               i1_reg <= i1_next;
               i2_reg <= i2_next;
            end else begin
               acc_reg <= acc_next;
            end
         end
      end

      assign out[gi] = out_reg;
   end

endmodule
